// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a single registered W-bit bitwise logic unit.
// One operation in flight at a time; each result is returned with its requester index.
module logic_unit_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [3*NREQ-1:0]         req_op,
  input  logic [W*NREQ-1:0]         req_a,
  input  logic [W*NREQ-1:0]         req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [W-1:0]              rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_NOTA, OP_ILL
  } op_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  op_t              op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic [2:0]       op_arr [NREQ];
  logic [W-1:0]     a_arr  [NREQ];
  logic [W-1:0]     b_arr  [NREQ];

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  logic [W-1:0]     res_data;
  logic             res_err;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[3*gi +: 3];
    assign a_arr[gi]  = req_a[W*gi +: W];
    assign b_arr[gi]  = req_b[W*gi +: W];
  end

  // Scan from the requester after the last grant, wrapping; first valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = last_q;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == S_IDLE && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_q)
      OP_AND:  res_data = a_q & b_q;
      OP_OR:   res_data = a_q | b_q;
      OP_NAND: res_data = ~(a_q & b_q);
      OP_NOR:  res_data = ~(a_q | b_q);
      OP_XOR:  res_data = a_q ^ b_q;
      OP_XNOR: res_data = ~(a_q ^ b_q);
      OP_NOTA: res_data = ~a_q;
      OP_ILL:  res_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          op_d    = op_t'(op_arr[grant_id]);
          a_d     = a_arr[grant_id];
          b_d     = b_arr[grant_id];
          last_d  = grant_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // last_q holds the id of the operation in flight, so no separate id register.
        rsp_data_d  = res_data;
        rsp_err_d   = res_err;
        rsp_id_d    = last_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= IDW'(NREQ - 1);
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: opcode vector table, scoreboard of accepted operations,
// and directed sequences for round-robin order, back-pressure, operand capture and reset.
module tb_logic_unit_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;

  logic_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
    int         acc_cyc;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  exp_t sb[$];
  int   grant_log[$];
  int   acc_log[$];
  int   hs_cyc = 0;
  logic prev_valid = 1'b0;

  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    model = {1'b0, a & b};
      3'd1:    model = {1'b0, a | b};
      3'd2:    model = {1'b0, ~(a & b)};
      3'd3:    model = {1'b0, ~(a | b)};
      3'd4:    model = {1'b0, a ^ b};
      3'd5:    model = {1'b0, ~(a ^ b)};
      3'd6:    model = {1'b0, ~a};
      default: model = {1'b1, 8'h00};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: actual=%s required=expected event", name, what);
  endtask

  // Scoreboard monitor: samples mid-cycle, when inputs and req_ready are settled.
  initial begin
    exp_t        e;
    logic [8:0]  r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            r = model(req_op[3*i +: 3], req_a[W*i +: W], req_b[W*i +: W]);
            e.id      = 2'(i);
            e.data    = r[7:0];
            e.err     = r[8];
            e.acc_cyc = cyc;
            sb.push_back(e);
            grant_log.push_back(i);
            acc_log.push_back(cyc);
          end
        end
        chk("ready_onehot", 32'($countones(req_ready) > 1), 32'(0));
        if (rsp_valid && !prev_valid) begin
          if (sb.size() == 0) fail_msg("rsp_unexpected", "rsp_valid with no accepted op");
          else chk("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'(2));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            fail_msg("rsp_handshake", "response with empty scoreboard");
          end else begin
            e = sb.pop_front();
            chk("sb_id",   32'(rsp_id),   32'(e.id));
            chk("sb_data", 32'(rsp_data), 32'(e.data));
            chk("sb_err",  32'(rsp_err),  32'(e.err));
            hs_cyc = cyc;
          end
        end
        prev_valid = rsp_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    sb.delete();
    grant_log.delete();
    acc_log.delete();
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic do_reset(input logic [NREQ-1:0] v);
    req_valid = v;
    rsp_ready = 1'b1;
    rst = 1'b1;
    clear_logs();
    tick();
    tick();
    chk("reset_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input bit drop, input string name);
    int base;
    int seen;
    base = grant_log.size();
    seen = base;
    for (int t = 0; t < 60 && grant_log.size() < base + n; t++) begin
      tick();
      while (seen < grant_log.size()) begin
        if (drop) req_valid[grant_log[seen]] = 1'b0;
        seen++;
      end
    end
    if (grant_log.size() < base + n) fail_msg(name, "timeout waiting for grant");
  endtask

  task automatic wait_rsp(input string name);
    int t;
    t = 0;
    while (!rsp_valid && t < 20) begin
      tick();
      t++;
    end
    if (!rsp_valid) fail_msg(name, "timeout waiting for rsp_valid");
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 40) begin
      tick();
      t++;
    end
    if (sb.size() != 0 || busy) fail_msg(name, "timeout draining responses");
  endtask

  initial begin
    vec_t vt[8];
    int   rr_exp[6];
    vt[0] = '{3'd0, 8'hC5, 8'h3A, 8'h00, 1'b0};
    vt[1] = '{3'd1, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vt[2] = '{3'd2, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vt[3] = '{3'd3, 8'hC5, 8'h3A, 8'h00, 1'b0};
    vt[4] = '{3'd4, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vt[5] = '{3'd5, 8'hC5, 8'h3A, 8'h00, 1'b0};
    vt[6] = '{3'd6, 8'hC5, 8'h3A, 8'h3A, 1'b0};
    vt[7] = '{3'd7, 8'hC5, 8'h3A, 8'h00, 1'b1};
    rr_exp = '{0, 1, 2, 3, 0, 1};

    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;

    // Reset state
    do_reset('0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data",  32'(rsp_data),  32'(0));
    chk("rst_rsp_id",    32'(rsp_id),    32'(0));
    chk("rst_rsp_err",   32'(rsp_err),   32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));

    // Opcode table on requester 0
    for (int v = 0; v < 8; v++) begin
      set_req(0, vt[v].op, vt[v].a, vt[v].b);
      req_valid[0] = 1'b1;
      wait_grants(1, 1'b1, "op_grant");
      chk("op_busy", 32'(busy), 32'(1));
      wait_rsp("op_rsp");
      chk("op_data", 32'(rsp_data), 32'(vt[v].exp_data));
      chk("op_err",  32'(rsp_err),  32'(vt[v].exp_err));
      chk("op_id",   32'(rsp_id),   32'(0));
      tick();
    end
    drain("op_drain");

    // Round-robin with every requester valid from reset
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 8'(i * 8'h11), 8'h0F);
    do_reset('1);
    wait_grants(6, 1'b0, "rr_grant");
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      if (grant_log.size() > k) chk("rr_order", 32'(grant_log[k]), 32'(rr_exp[k]));
      if (k > 0 && acc_log.size() > k) chk("rr_spacing", 32'(acc_log[k] - acc_log[k-1]), 32'(3));
    end
    drain("rr_drain");

    // Back-pressure: response held for 5 cycles, requester 2 waits
    do_reset('0);
    rsp_ready = 1'b0;
    set_req(1, 3'd1, 8'h55, 8'hA0);
    set_req(2, 3'd0, 8'hFF, 8'h0F);
    req_valid = 4'b0110;
    wait_grants(1, 1'b1, "bp_grant1");
    if (grant_log.size() > 0) chk("bp_first", 32'(grant_log[0]), 32'(1));
    wait_rsp("bp_rsp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_data",  32'(rsp_data),  32'(8'hF5));
      chk("bp_id",    32'(rsp_id),    32'(1));
      chk("bp_err",   32'(rsp_err),   32'(0));
      chk("bp_ready", 32'(req_ready), 32'(0));
      tick();
    end
    rsp_ready = 1'b1;
    wait_grants(1, 1'b1, "bp_grant2");
    if (grant_log.size() > 1) begin
      chk("bp_second", 32'(grant_log[1]), 32'(2));
      chk("bp_after_hs", 32'(acc_log[1] - hs_cyc), 32'(1));
    end
    drain("bp_drain");

    // Operand change right after accept must not affect the result
    do_reset('0);
    set_req(2, 3'd4, 8'hF0, 8'hFF);
    req_valid = 4'b0100;
    wait_grants(1, 1'b1, "hold_grant");
    req_a[W*2 +: W] = 8'h0F;
    wait_rsp("hold_rsp");
    chk("hold_data", 32'(rsp_data), 32'(8'h0F));
    chk("hold_id",   32'(rsp_id),   32'(2));
    drain("hold_drain");

    // Pointer fairness: after granting 1, requester 3 beats requester 0
    do_reset('0);
    set_req(1, 3'd0, 8'hAA, 8'hF0);
    req_valid = 4'b0010;
    wait_grants(1, 1'b1, "fair_grant1");
    set_req(0, 3'd6, 8'h12, 8'h00);
    set_req(3, 3'd6, 8'h34, 8'h00);
    req_valid = 4'b1001;
    wait_grants(2, 1'b1, "fair_grant2");
    if (grant_log.size() > 2) begin
      chk("fair_first",  32'(grant_log[1]), 32'(3));
      chk("fair_second", 32'(grant_log[2]), 32'(0));
    end
    drain("fair_drain");

    // Reset during EXEC discards the operation
    do_reset('0);
    set_req(0, 3'd0, 8'hFF, 8'hFF);
    req_valid = 4'b0001;
    wait_grants(1, 1'b1, "mid_grant");
    chk("mid_busy_pre", 32'(busy), 32'(1));
    rst = 1'b1;
    clear_logs();
    #1;
    chk("mid_busy",  32'(busy),      32'(0));
    chk("mid_valid", 32'(rsp_valid), 32'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_no_rsp", 32'(rsp_valid), 32'(0));
      tick();
    end
    set_req(0, 3'd1, 8'h0C, 8'h30);
    set_req(1, 3'd2, 8'hF0, 8'h3C);
    req_valid = 4'b0011;
    wait_grants(2, 1'b1, "mid_regrant");
    if (grant_log.size() > 1) begin
      chk("mid_first",  32'(grant_log[0]), 32'(0));
      chk("mid_second", 32'(grant_log[1]), 32'(1));
    end
    drain("mid_drain");

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=time limit reached required=bench completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered W-bit bitwise logic unit between NREQ requesters.
- The unit supports AND, OR, NAND, NOR, XOR, XNOR and NOT-a.
- Requesters are granted round-robin through a valid/ready handshake.
- Each accepted operation returns one result, tagged with the requester index, on a single valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- IDW, $clog2(NREQ), width of rsp_id (derived, not overridable)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high
- req_op  in  3*NREQ  opcode, requester i at bits [3i+2:3i]
- req_a  in  W*NREQ  operand a, requester i at bits [Wi+W-1:Wi]
- req_b  in  W*NREQ  operand b, same packing as req_a
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that issued the result
- rsp_data  out  W  result
- rsp_err  out  1  opcode was illegal
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, req_ready=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
- Opcodes, bitwise over W bits:
  - 0 a&b; 1 a|b; 2 ~(a&b); 3 ~(a|b); 4 a^b; 5 ~(a^b); 6 ~a (b ignored).
  - 7 is illegal: rsp_data=0, rsp_err=1.
- State IDLE:
  - Search req_valid starting at index (last+1) mod NREQ, wrapping; the first set bit is g.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - Accept occurs on that edge: capture op, a, b and id=g; set last=g; go to EXEC.
  - No req_valid set: stay in IDLE, all req_ready=0, last unchanged.
- State EXEC (one cycle):
  - Register rsp_data, rsp_err and rsp_id from the captured operands.
  - Set rsp_valid=1; go to RESP.
- State RESP:
  - Hold rsp_valid, rsp_data, rsp_id and rsp_err stable until rsp_ready=1.
  - On that edge: rsp_valid=0, go to IDLE.
  - rsp_data, rsp_id and rsp_err keep their last values after the handshake.
- Latency: accept at edge N; rsp_valid high from after edge N+1. With rsp_ready tied high, the minimum issue interval is 3 cycles.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands until they see ready.
- A requester may drop req_valid while un-granted; this is legal and creates no commitment.
- Operand changes after the accept edge do not affect the result (captured copy is used).
- Simultaneous requests: exactly one grant per accept, in round-robin order. No requester waits more than NREQ-1 grants.
- rsp_ready asserted outside RESP is ignored.
- Reset asserted mid-operation:
  - The in-flight operation is discarded; no response is produced for it.
  - All outputs and the pointer return to reset values immediately (asynchronous).
- busy = (state != IDLE).

Test Plan:
- Single op, per opcode: req 0, a=8'hC5, b=8'h3A, op=0..7, rsp_ready=1.
  - Required rsp_data: 00, FF, FF, 00, FF, 00, 3A; op 7 gives 00 with rsp_err=1.
  - rsp_id=0; rsp_valid exactly 2 cycles after the accept edge.
- Round-robin: all 4 requesters valid continuously from reset.
  - Grant order 0,1,2,3,0,1; rsp_id follows the same order.
  - Accept edges spaced exactly 3 cycles apart.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_data, rsp_id and rsp_err stay stable.
  - req_ready stays 0 for every requester; the next grant comes only in the cycle after the handshake.
- Operand hold-off: requester 2 changes a from 8'hF0 to 8'h0F the cycle after its accept, op=4, b=8'hFF.
  - rsp_data=8'h0F, computed from the captured F0.
- Pointer fairness: after a grant to 1, requesters 0 and 3 both become valid.
  - Requester 3 is granted first, then requester 0.
- Reset mid-op: assert rst during EXEC for one cycle.
  - rsp_valid stays 0 and busy=0 immediately.
  - Next request from requesters 0 and 1 grants 0 first.
